// File: rtl/data_mem_pkg.sv
// Shared definitions for the pipelined data memory.
//   state_e   : controller state (ST_CLEAR while zeroing the array, ST_IDLE when serving accesses)
//   calc_lsb  : number of byte-lane bits in a byte address for a given word width
//   ext_fill  : fill bit used when widening a loaded byte (0 for zero-extend, bit 7 for sign-extend)
package data_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int unsigned calc_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic ext_fill(input logic [7:0] b, input logic is_unsigned);
    return is_unsigned ? 1'b0 : b[7];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Ports:
//   clk, rst_n : clock and async active-low reset (read register only; array is not reset)
//   wbe_i      : per-byte write enable for word waddr_i
//   waddr_i    : write word index
//   wdata_i    : write data, byte b on bits [8b+7:8b]
//   re_i       : read enable; rdata_o only updates when set
//   raddr_i    : read word index
//   rdata_o    : registered read data, write-first against the same-edge write
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W/8-1:0]     wbe_i,
  input  logic [DEPTH_LOG2-1:0]   waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [DEPTH_LOG2-1:0]   raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Bypass per byte so a byte-merged store in the same cycle is seen by the load.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      for (int b = 0; b < NB; b++) begin
        rdata_d[b*8 +: 8] = (wbe_i[b] && (waddr_i == raddr_i)) ? wdata_i[b*8 +: 8]
                                                               : mem_q[raddr_i][b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_pipe.sv
// Pipelined data memory: byte-addressed word/byte loads and stores, sign/zero
// extension, RD_LAT (1 or 2) cycle read latency, misalignment flag and a
// post-reset clear sequence.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   mem_addr        : byte address (bits above the word index alias)
//   mem_wdata       : store data (byte stores use [7:0])
//   mem_write/read  : store / load request
//   mem_byte        : 1 = byte access, 0 = word access
//   mem_unsigned    : byte loads: 1 = zero-extend, 0 = sign-extend
//   ready           : high once the array has been cleared
//   rd_data/rd_valid: load result and its one-cycle valid pulse
//   err_misalign    : one-cycle pulse for a misaligned word access
//
// state    | meaning
// ST_CLEAR | zeroing word clr_ptr_q each cycle, requests ignored
// ST_IDLE  | serving loads and stores
module data_memory_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              mem_byte,
  input  logic              mem_unsigned,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err_misalign
);

  localparam int LSB = int'(calc_lsb(DATA_W));
  localparam int NB  = DATA_W / 8;

  logic [DEPTH_LOG2-1:0] idx;
  logic [LSB-1:0]        lane;
  logic                  lane_nz;
  logic                  unused_addr;

  assign idx         = mem_addr[LSB+DEPTH_LOG2-1:LSB];
  assign lane        = mem_addr[LSB-1:0];
  assign lane_nz     = (lane != '0);
  assign unused_addr = ^mem_addr[ADDR_W-1:LSB+DEPTH_LOG2];

  // FSM
  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE:  state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    clearing = (state_q == ST_CLEAR);
  end

  // Access decode
  logic acc_wr, acc_rd, misalign;

  assign acc_wr   = ready & mem_write;
  assign acc_rd   = ready & mem_read;
  // A combined misaligned load+store is one access and yields one pulse.
  assign misalign = (acc_wr | acc_rd) & ~mem_byte & lane_nz;

  logic [NB-1:0]         arr_wbe;
  logic [DEPTH_LOG2-1:0] arr_waddr;
  logic [DATA_W-1:0]     arr_wdata;
  logic [DATA_W-1:0]     arr_rdata;

  always_comb begin
    arr_wbe   = '0;
    arr_waddr = idx;
    arr_wdata = mem_wdata;
    if (clearing) begin
      arr_wbe   = '1;
      arr_waddr = clr_ptr_q;
      arr_wdata = '0;
    end else if (acc_wr) begin
      if (mem_byte) begin
        arr_wbe   = NB'(1) << lane;
        arr_wdata = {NB{mem_wdata[7:0]}};
      end else if (!lane_nz) begin
        arr_wbe   = '1;
      end
    end
  end

  dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wbe_i  (arr_wbe),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .re_i   (acc_rd),
    .raddr_i(idx),
    .rdata_o(arr_rdata)
  );

  // First stage: load attributes captured at the request edge. They only
  // change on a new load so the formatted result holds between loads.
  logic           s1_valid_q, s1_err_q, s1_byte_q, s1_uns_q, s1_zero_q;
  logic [LSB-1:0] s1_lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_byte_q  <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_lane_q  <= '0;
    end else begin
      s1_valid_q <= acc_rd;
      s1_err_q   <= misalign;
      if (acc_rd) begin
        s1_byte_q <= mem_byte;
        s1_uns_q  <= mem_unsigned;
        s1_zero_q <= ~mem_byte & lane_nz;
        s1_lane_q <= lane;
      end
    end
  end

  logic [7:0]        sel_byte;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    sel_byte = arr_rdata[{s1_lane_q, 3'b000} +: 8];
    if (s1_zero_q)      ld_data = '0;
    else if (s1_byte_q) ld_data = {{(DATA_W-8){ext_fill(sel_byte, s1_uns_q)}}, sel_byte};
    else                ld_data = arr_rdata;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        rd_valid_q <= s1_valid_q;
        err_q      <= s1_err_q;
        if (s1_valid_q) rd_data_q <= ld_data;
      end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign err_misalign = err_q;
  end else begin : g_lat1
    assign rd_data      = ld_data;
    assign rd_valid     = s1_valid_q;
    assign err_misalign = s1_err_q;
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
module tb_data_memory_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_byte = 1'b0;
  logic        mem_unsigned = 1'b0;

  logic        ready1, rd_valid1, err1;
  logic [15:0] rd_data1;
  logic        ready2, rd_valid2, err2;
  logic [15:0] rd_data2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_memory_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_byte(mem_byte),
    .mem_unsigned(mem_unsigned), .ready(ready1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .err_misalign(err1)
  );

  data_memory_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_byte(mem_byte),
    .mem_unsigned(mem_unsigned), .ready(ready2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .err_misalign(err2)
  );

  task automatic drive(input logic wr, input logic rd, input logic byt, input logic uns,
                       input logic [15:0] addr, input logic [15:0] data);
    mem_write = wr; mem_read = rd; mem_byte = byt; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    tick(); tick();
    total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready1); end
    total++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b/%b exp=0", rd_valid1, rd_valid2); end
    total++; if (err1 !== 1'b0 || err2 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b/%b exp=0", err1, err2); end
    total++; if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h/%h exp=0000", rd_data1, rd_data2); end
  endtask

  task automatic test_clear(input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    while (n < 300) begin
      tick();
      n++;
      if (rd_valid1 || rd_valid2 || err1 || err2) seen = 1'b1;
      if (ready1) break;
    end
    idle();
    total++; if (n !== 256) begin bad++; $display("FAIL %s_len got=%0d exp=256", tag, n); end
    total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL %s_ready2 got=%b exp=1", tag, ready2); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL %s_ignored got=%b exp=0", tag, seen); end
    tick();
    total++; if (rd_valid1 !== 1'b0) begin bad++; $display("FAIL %s_novalid got=%b exp=0", tag, rd_valid1); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0000) begin bad++; $display("FAIL %s_ld1 got=%b/%h exp=1/0000", tag, rd_valid1, rd_data1); end
    tick();
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h0000) begin bad++; $display("FAIL %s_ld2 got=%b/%h exp=1/0000", tag, rd_valid2, rd_data2); end
  endtask

  task automatic test_word();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'hABCD);
    tick();
    total++; if (err1 !== 1'b0 || rd_valid1 !== 1'b0) begin bad++; $display("FAIL wst_flags got=%b/%b exp=0/0", err1, rd_valid1); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hABCD) begin bad++; $display("FAIL wld1 got=%b/%h exp=1/abcd", rd_valid1, rd_data1); end
    total++; if (rd_valid2 !== 1'b0) begin bad++; $display("FAIL wld2_early got=%b exp=0", rd_valid2); end
    tick();
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'hABCD) begin bad++; $display("FAIL wld2 got=%b/%h exp=1/abcd", rd_valid2, rd_data2); end
    total++; if (rd_valid1 !== 1'b0 || rd_data1 !== 16'hABCD) begin bad++; $display("FAIL wld1_hold got=%b/%h exp=0/abcd", rd_valid1, rd_data1); end
    tick();
    total++; if (rd_valid2 !== 1'b0 || rd_data2 !== 16'hABCD) begin bad++; $display("FAIL wld2_hold got=%b/%h exp=0/abcd", rd_valid2, rd_data2); end
  endtask

  task automatic test_bytes();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h1234);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'hAAF0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    tick();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hF034) begin bad++; $display("FAIL byte_word got=%b/%h exp=1/f034", rd_valid1, rd_data1); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    tick();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hFFF0) begin bad++; $display("FAIL byte_sext got=%b/%h exp=1/fff0", rd_valid1, rd_data1); end
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'hF034) begin bad++; $display("FAIL byte_word2 got=%b/%h exp=1/f034", rd_valid2, rd_data2); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0011, 16'h0000);
    tick();
    total++; if (rd_data1 !== 16'h00F0) begin bad++; $display("FAIL byte_zext got=%h exp=00f0", rd_data1); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    idle();
    total++; if (rd_data1 !== 16'h0034) begin bad++; $display("FAIL byte_lane0 got=%h exp=0034", rd_data1); end
    tick();
    total++; if (rd_data2 !== 16'h0034) begin bad++; $display("FAIL byte_lane0_2 got=%h exp=0034", rd_data2); end
  endtask

  task automatic test_alias();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h1234);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h01FE, 16'h0000);
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h1234) begin bad++; $display("FAIL alias got=%b/%h exp=1/1234", rd_valid1, rd_data1); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 16'h5678);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h9999);
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h5678) begin bad++; $display("FAIL rw_fwd got=%b/%h exp=1/5678", rd_valid1, rd_data1); end
    tick();
    idle();
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h5678) begin bad++; $display("FAIL rw_inflight2 got=%b/%h exp=1/5678", rd_valid2, rd_data2); end
    total++; if (rd_valid1 !== 1'b0 || rd_data1 !== 16'h5678) begin bad++; $display("FAIL rw_hold1 got=%b/%h exp=0/5678", rd_valid1, rd_data1); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0077);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 16'h0000);
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0077) begin bad++; $display("FAIL rw_byte_fwd got=%b/%h exp=1/0077", rd_valid1, rd_data1); end
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h7799) begin bad++; $display("FAIL rw_merged got=%b/%h exp=1/7799", rd_valid1, rd_data1); end
    tick();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h2222);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'hDEAD);
    tick();
    idle();
    total++; if (err1 !== 1'b1 || rd_valid1 !== 1'b0) begin bad++; $display("FAIL mis_st1 got=%b/%b exp=1/0", err1, rd_valid1); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL mis_st2_early got=%b exp=0", err2); end
    tick();
    total++; if (err1 !== 1'b0 || err2 !== 1'b1) begin bad++; $display("FAIL mis_st_pulse got=%b/%b exp=0/1", err1, err2); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
    tick();
    total++; if (rd_data1 !== 16'h2222 || err1 !== 1'b0) begin bad++; $display("FAIL mis_unchanged got=%h/%b exp=2222/0", rd_data1, err1); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0000 || err1 !== 1'b1) begin bad++; $display("FAIL mis_ld1 got=%b/%h/%b exp=1/0000/1", rd_valid1, rd_data1, err1); end
    tick();
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h0000 || err2 !== 1'b1) begin bad++; $display("FAIL mis_ld2 got=%b/%h/%b exp=1/0000/1", rd_valid2, rd_data2, err2); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h1111);
    tick();
    idle();
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL mis_rw got=%b exp=1", err1); end
    tick();
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL mis_rw_single got=%b exp=0", err1); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h4444);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    total++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b/%b exp=0/0", rd_valid1, rd_valid2); end
    total++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b/%b exp=0/0", ready1, ready2); end
    tick();
    total++; if (rd_valid2 !== 1'b0) begin bad++; $display("FAIL rmid_drop got=%b exp=0", rd_valid2); end
  endtask

  task automatic test_after_reclear();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    idle();
    total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0000) begin bad++; $display("FAIL reclear_zero got=%b/%h exp=1/0000", rd_valid1, rd_data1); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear("clear");
    test_word();
    test_bytes();
    test_alias();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_clear("reclear");
    test_after_reclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
